// File: rtl/psram_frame_arbiter_if.sv
// Handshake and buffer-address bundle between the frame datapath FSMs and the PSRAM port arbiter.
// master = requester/datapath side, slave = arbiter side.
interface psram_frame_arbiter_if;
    logic        mem_ready;
    logic        wr_rq;
    logic        wr_ack;
    logic        rd_rq;
    logic        rd_ack;
    logic        mem_sel;
    logic        busy;
    logic        upload_done;
    logic        rd_frame_start;
    logic [20:0] wr_base_addr;
    logic [20:0] rd_base_addr;
    logic        new_frame;

    modport master (
        output mem_ready, wr_rq, rd_rq, upload_done, rd_frame_start,
        input  wr_ack, rd_ack, mem_sel, busy, wr_base_addr, rd_base_addr, new_frame
    );

    modport slave (
        input  mem_ready, wr_rq, rd_rq, upload_done, rd_frame_start,
        output wr_ack, rd_ack, mem_sel, busy, wr_base_addr, rd_base_addr, new_frame
    );
endinterface

// File: rtl/psram_frame_arbiter.sv
// PSRAM port arbiter (read priority, optional ARB_STARVE_GUARD_EN write anti-starvation) plus triple-buffer rotation.
// Latency: grant one cycle after a request is sampled in IDLE; buffer addresses update one cycle after a pulse.
// Backpressure: requests are ignored while the port is held for TCMD cycles; requesters hold rq until ack.
module psram_frame_arbiter #(
    parameter int          TCMD          = 19,
    parameter logic [20:0] BUF_ADDR_0    = 21'h000000,
    parameter logic [20:0] BUF_ADDR_1    = 21'h04B000,
    parameter logic [20:0] BUF_ADDR_2    = 21'h096000,
    parameter int          MAX_RD_STREAK = 4
) (
    input logic                   clk,
    input logic                   reset_n,
    psram_frame_arbiter_if.slave  bus
);

    if (TCMD < 2 || TCMD > 64 || MAX_RD_STREAK < 1 || MAX_RD_STREAK > 15) begin : g_bad_param
        $error("psram_frame_arbiter: TCMD must be 2..64 and MAX_RD_STREAK 1..15");
    end

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [5:0] CNT_LAST = 6'(TCMD - 1);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        wr_ack_q, wr_ack_d;
    logic        rd_ack_q, rd_ack_d;
    logic        mem_sel_q, mem_sel_d;
    logic        busy_q, busy_d;

    logic        can_grant;
    logic        force_wr;
    logic        grant_rd;
    logic        grant_wr;

    assign can_grant = (state_q == IDLE) && bus.mem_ready;

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] rd_streak_q, rd_streak_d;

    // Once the reader has won MAX_RD_STREAK times in a row against a waiting writer, yield once.
    assign force_wr = bus.wr_rq && (rd_streak_q == 4'(MAX_RD_STREAK));

    always_comb begin
        rd_streak_d = rd_streak_q;
        if (grant_rd) begin
            rd_streak_d = bus.wr_rq ? rd_streak_q + 4'd1 : 4'd0;
        end else if (grant_wr) begin
            rd_streak_d = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_streak_q <= 4'd0;
        end else begin
            rd_streak_q <= rd_streak_d;
        end
    end
`else
    assign force_wr = 1'b0;
`endif

    assign grant_rd = can_grant && bus.rd_rq && !force_wr;
    assign grant_wr = can_grant && bus.wr_rq && !grant_rd;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_ack_d  = 1'b0;
        rd_ack_d  = 1'b0;
        mem_sel_d = mem_sel_q;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                if (grant_rd || grant_wr) begin
                    state_d   = HOLD;
                    cnt_d     = 6'd0;
                    rd_ack_d  = grant_rd;
                    wr_ack_d  = grant_wr;
                    mem_sel_d = grant_rd;
                    busy_d    = 1'b1;
                end
            end
            HOLD: begin
                // The ack cycle is count 0, so the port is owned for exactly TCMD cycles.
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            mem_sel_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_ack_q  <= wr_ack_d;
            rd_ack_q  <= rd_ack_d;
            mem_sel_q <= mem_sel_d;
            busy_q    <= busy_d;
        end
    end

    function automatic logic [20:0] buf_addr(input logic [1:0] idx);
        case (idx)
            2'd1:    buf_addr = BUF_ADDR_1;
            2'd2:    buf_addr = BUF_ADDR_2;
            default: buf_addr = BUF_ADDR_0;
        endcase
    endfunction

    logic [1:0]  wr_idx_q, wr_idx_d;
    logic [1:0]  ready_idx_q, ready_idx_d;
    logic [1:0]  rd_idx_q, rd_idx_d;
    logic        new_frame_q, new_frame_d;
    logic [20:0] wr_addr_q, rd_addr_q;

    always_comb begin
        wr_idx_d    = wr_idx_q;
        ready_idx_d = ready_idx_q;
        rd_idx_d    = rd_idx_q;
        new_frame_d = new_frame_q;
        case ({bus.upload_done, bus.rd_frame_start})
            2'b10: begin
                wr_idx_d    = ready_idx_q;
                ready_idx_d = wr_idx_q;
                new_frame_d = 1'b1;
            end
            2'b01: begin
                // With nothing new pending the reader simply repeats its frame.
                if (new_frame_q) begin
                    rd_idx_d    = ready_idx_q;
                    ready_idx_d = rd_idx_q;
                    new_frame_d = 1'b0;
                end
            end
            2'b11: begin
                // The just-finished frame goes straight to the reader.
                rd_idx_d    = wr_idx_q;
                wr_idx_d    = ready_idx_q;
                ready_idx_d = rd_idx_q;
                new_frame_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_idx_q    <= 2'd0;
            ready_idx_q <= 2'd1;
            rd_idx_q    <= 2'd2;
            new_frame_q <= 1'b0;
            wr_addr_q   <= BUF_ADDR_0;
            rd_addr_q   <= BUF_ADDR_2;
        end else begin
            wr_idx_q    <= wr_idx_d;
            ready_idx_q <= ready_idx_d;
            rd_idx_q    <= rd_idx_d;
            new_frame_q <= new_frame_d;
            wr_addr_q   <= buf_addr(wr_idx_d);
            rd_addr_q   <= buf_addr(rd_idx_d);
        end
    end

    assign bus.wr_ack       = wr_ack_q;
    assign bus.rd_ack       = rd_ack_q;
    assign bus.mem_sel      = mem_sel_q;
    assign bus.busy         = busy_q;
    assign bus.wr_base_addr = wr_addr_q;
    assign bus.rd_base_addr = rd_addr_q;
    assign bus.new_frame    = new_frame_q;

endmodule

// File: tb/tb_psram_frame_arbiter.sv
// Scoreboard bench for psram_frame_arbiter: grant and buffer-rotation expectations are queued at stimulus time.
module tb_psram_frame_arbiter;
    localparam int          TCMD = 19;
    localparam logic [20:0] B0   = 21'h000000;
    localparam logic [20:0] B1   = 21'h04B000;
    localparam logic [20:0] B2   = 21'h096000;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    psram_frame_arbiter_if bus();

    psram_frame_arbiter #(
        .TCMD(TCMD), .BUF_ADDR_0(B0), .BUF_ADDR_1(B1), .BUF_ADDR_2(B2), .MAX_RD_STREAK(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int errors  = 0;

    typedef struct { bit is_rd; int at; } grant_t;
    typedef struct { logic [20:0] wr; logic [20:0] rd; logic nf; } rot_t;
    grant_t gq[$];
    rot_t   rq[$];

    function automatic logic [20:0] addr_of(input int idx);
        return (idx == 0) ? B0 : (idx == 1) ? B1 : B2;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        bus.mem_ready = 1'b0; bus.wr_rq = 1'b0; bus.rd_rq = 1'b0;
        bus.upload_done = 1'b0; bus.rd_frame_start = 1'b0;
        @(negedge clk);
        vectors++; if (bus.wr_ack !== 1'b0) begin errors++; $display("FAIL reset_wr_ack: got %b expected 0", bus.wr_ack); end
        vectors++; if (bus.rd_ack !== 1'b0) begin errors++; $display("FAIL reset_rd_ack: got %b expected 0", bus.rd_ack); end
        vectors++; if (bus.mem_sel !== 1'b0) begin errors++; $display("FAIL reset_mem_sel: got %b expected 0", bus.mem_sel); end
        vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        vectors++; if (bus.new_frame !== 1'b0) begin errors++; $display("FAIL reset_new_frame: got %b expected 0", bus.new_frame); end
        vectors++; if (bus.wr_base_addr !== B0) begin errors++; $display("FAIL reset_wr_base: got %h expected %h", bus.wr_base_addr, B0); end
        vectors++; if (bus.rd_base_addr !== B2) begin errors++; $display("FAIL reset_rd_base: got %h expected %h", bus.rd_base_addr, B2); end
        reset_n = 1'b1;
        bus.wr_rq = 1'b1; bus.rd_rq = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.wr_ack, bus.rd_ack, bus.busy} !== 3'b000) begin
                errors++;
                $display("FAIL no_grant_unready: got ack/busy %b expected 000", {bus.wr_ack, bus.rd_ack, bus.busy});
            end
        end
        bus.wr_rq = 1'b0; bus.rd_rq = 1'b0;
    endtask

    task automatic test_single_write();
        int  t0;
        bit  exp_busy;
        @(negedge clk);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        t0 = cyc;
        bus.wr_rq = 1'b1;
        gq.push_back('{1'b0, t0 + 1});
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            vectors++;
            if (gq.size() > 0 && gq[0].at == cyc) begin
                if ({bus.wr_ack, bus.rd_ack} !== {!gq[0].is_rd, gq[0].is_rd}) begin
                    errors++;
                    $display("FAIL write_ack cyc=%0d: got wr/rd %b expected %b", cyc - t0, {bus.wr_ack, bus.rd_ack}, {!gq[0].is_rd, gq[0].is_rd});
                end
                void'(gq.pop_front());
            end else if ({bus.wr_ack, bus.rd_ack} !== 2'b00) begin
                errors++;
                $display("FAIL write_spurious_ack cyc=%0d: got %b expected 00", cyc - t0, {bus.wr_ack, bus.rd_ack});
            end
            exp_busy = (cyc >= t0 + 1) && (cyc <= t0 + TCMD);
            vectors++;
            if (bus.busy !== exp_busy) begin
                errors++;
                $display("FAIL write_busy cyc=%0d: got %b expected %b", cyc - t0, bus.busy, exp_busy);
            end
            if (exp_busy) begin
                vectors++;
                if (bus.mem_sel !== 1'b0) begin errors++; $display("FAIL write_mem_sel: got %b expected 0", bus.mem_sel); end
            end
            if (cyc == t0 + 1) bus.wr_rq = 1'b0;
            if (cyc == t0 + 3) bus.mem_ready = 1'b0;
            if (cyc == t0 + 5) bus.rd_rq = 1'b1;
        end
        bus.rd_rq = 1'b0;
        bus.mem_ready = 1'b1;
        vectors++;
        if (gq.size() != 0) begin errors++; $display("FAIL write_timeout: got %0d pending grants expected 0", gq.size()); end
        gq.delete();
    endtask

    task automatic test_contention();
        int t0;
        int ng;
        int k = 0;
        bit cur_rd = 1'b0;
        bit is_rd;
`ifdef ARB_STARVE_GUARD_EN
        ng = 11;
`else
        ng = 6;
`endif
        @(negedge clk);
        t0 = cyc;
        bus.wr_rq = 1'b1; bus.rd_rq = 1'b1;
        for (int i = 0; i < ng; i++) begin
`ifdef ARB_STARVE_GUARD_EN
            is_rd = (i < 10) && (i % 5 != 4);
`else
            is_rd = (i < 5);
`endif
            gq.push_back('{is_rd, t0 + 1 + (TCMD + 1) * i});
        end
        for (int i = 0; i < ng * (TCMD + 1) + 5; i++) begin
            @(negedge clk);
            vectors++;
            if (gq.size() > 0 && gq[0].at == cyc) begin
                if ({bus.wr_ack, bus.rd_ack} !== {!gq[0].is_rd, gq[0].is_rd}) begin
                    errors++;
                    $display("FAIL contention_grant%0d: got wr/rd %b expected %b", k, {bus.wr_ack, bus.rd_ack}, {!gq[0].is_rd, gq[0].is_rd});
                end
                cur_rd = gq[0].is_rd;
                void'(gq.pop_front());
                k++;
                if (k == ng - 1) bus.rd_rq = 1'b0;
                if (k == ng) bus.wr_rq = 1'b0;
            end else if ({bus.wr_ack, bus.rd_ack} !== 2'b00) begin
                errors++;
                $display("FAIL contention_spurious_ack cyc=%0d: got %b expected 00", cyc - t0, {bus.wr_ack, bus.rd_ack});
            end
            if (bus.busy === 1'b1 && k > 0) begin
                vectors++;
                if (bus.mem_sel !== cur_rd) begin errors++; $display("FAIL contention_mem_sel: got %b expected %b", bus.mem_sel, cur_rd); end
            end
        end
        bus.wr_rq = 1'b0; bus.rd_rq = 1'b0;
        vectors++;
        if (gq.size() != 0) begin errors++; $display("FAIL contention_timeout: got %0d pending grants expected 0", gq.size()); end
        gq.delete();
    endtask

    task automatic test_rotation();
        int  mw = 1, my = 2, md = 0, tmp;
        bit  mnf = 1'b0;
        bit  u, s;
        rot_t e;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            if (rq.size() > 0) begin
                e = rq.pop_front();
                vectors++;
                if ({bus.wr_base_addr, bus.rd_base_addr, bus.new_frame} !== {e.wr, e.rd, e.nf}) begin
                    errors++;
                    $display("FAIL rotation_step%0d: got wr=%h rd=%h nf=%b expected wr=%h rd=%h nf=%b",
                             i, bus.wr_base_addr, bus.rd_base_addr, bus.new_frame, e.wr, e.rd, e.nf);
                end
            end
            if (i == 33) begin
                bus.upload_done = 1'b0; bus.rd_frame_start = 1'b0;
            end else if (i < 3) begin
                bus.upload_done    = (i == 0);
                bus.rd_frame_start = (i != 0);
                if (i == 0) rq.push_back('{B1, B2, 1'b1});
                else        rq.push_back('{B1, B0, 1'b0});
            end else begin
                u = 1'($urandom_range(0, 1));
                s = 1'($urandom_range(0, 1));
                bus.upload_done = u; bus.rd_frame_start = s;
                if (u && !s) begin
                    tmp = mw; mw = my; my = tmp; mnf = 1'b1;
                end else if (!u && s && mnf) begin
                    tmp = md; md = my; my = tmp; mnf = 1'b0;
                end else if (u && s) begin
                    tmp = md; md = mw; mw = my; my = tmp; mnf = 1'b0;
                end
                rq.push_back('{addr_of(mw), addr_of(md), mnf});
            end
        end
        vectors++;
        if (rq.size() != 0) begin errors++; $display("FAIL rotation_pending: got %0d expected 0", rq.size()); end
        rq.delete();
    endtask

    task automatic test_simul_and_reset();
        rot_t e;
        bit   seen = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        bus.upload_done = 1'b1; bus.rd_frame_start = 1'b1;
        rq.push_back('{B1, B0, 1'b0});
        @(negedge clk);
        bus.upload_done = 1'b0; bus.rd_frame_start = 1'b0;
        e = rq.pop_front();
        vectors++;
        if ({bus.wr_base_addr, bus.rd_base_addr, bus.new_frame} !== {e.wr, e.rd, e.nf}) begin
            errors++;
            $display("FAIL simultaneous: got wr=%h rd=%h nf=%b expected wr=%h rd=%h nf=%b",
                     bus.wr_base_addr, bus.rd_base_addr, bus.new_frame, e.wr, e.rd, e.nf);
        end
        bus.mem_ready = 1'b1;
        bus.rd_rq = 1'b1;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            seen = (bus.rd_ack === 1'b1);
        end
        bus.rd_rq = 1'b0;
        vectors++;
        if (!seen) begin errors++; $display("FAIL hold_read_grant: got no rd_ack expected one within 5 cycles"); end
        repeat (4) @(negedge clk);
        vectors++;
        if ({bus.busy, bus.mem_sel} !== 2'b11) begin errors++; $display("FAIL hold_pre_reset: got busy/sel %b expected 11", {bus.busy, bus.mem_sel}); end
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({bus.busy, bus.mem_sel, bus.rd_ack, bus.wr_ack} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset_ctrl: got busy/sel/rd/wr %b expected 0000", {bus.busy, bus.mem_sel, bus.rd_ack, bus.wr_ack});
        end
        vectors++;
        if ({bus.wr_base_addr, bus.rd_base_addr, bus.new_frame} !== {B0, B2, 1'b0}) begin
            errors++;
            $display("FAIL async_reset_bufs: got wr=%h rd=%h nf=%b expected wr=%h rd=%h nf=0",
                     bus.wr_base_addr, bus.rd_base_addr, bus.new_frame, B0, B2);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_rotation();
        test_simul_and_reset();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
